slice_vlc_sequencer: RTL and testbench

Parametrised per-slice sequencer for the ProRes encoder datapath. It is the successor of the free-running block sequencer. It adds a slice-start handshake, latched block count, run/enable windows derived from parameters, a done/busy indication and start-error reporting. It sits between the slice controller and the DCT → DC VLC → AC VLC pipeline and drives the reset/enable/flush controls of both VLC stages.

---
 rtl/slice_vlc_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_slice_vlc_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_vlc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : slice_vlc_sequencer
//  Purpose  : Per-slice sequencer for the ProRes encoder datapath. Accepts a
//             slice-start handshake, latches the block count, then steps a
//             slice cycle counter through DCT, DC VLC and AC VLC phases. It
//             drives the run/enable/flush controls of both VLC stages from
//             windows derived from the latched block count.
//  Ports    : clock                 rising-edge clock
//             reset_n               asynchronous active-low reset
//             slice_start           one-cycle slice request
//             block_num             blocks in the slice (sampled on accept)
//             busy / done           slice in progress / end-of-slice pulse
//             start_err             pulse when a start is rejected
//             state                 0 IDLE, 1 DCT, 2 DC, 3 AC, 4 DONE
//             seq_count             cycles since start acceptance
//             dc_vlc_*              DC VLC run, output window, stage counter
//             ac_vlc_*              AC VLC run, output window, flush, counter
//  Revision : 1.0 - initial release
// ============================================================================
module slice_vlc_sequencer #(
    parameter int CNT_W       = 16,
    parameter int BN_W        = 8,
    parameter int COEFS       = 64,
    parameter int DCT_LAT     = 10,
    parameter int DC_VLC_LAT  = 44,
    parameter int DC_EN_DLY   = 7,
    parameter int AC_EN_DLY   = 6,
    parameter int DC_RUN_TAIL = 8,
    parameter int AC_RUN_TAIL = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             slice_start,
    input  logic [BN_W-1:0]  block_num,
    output logic             busy,
    output logic             done,
    output logic             start_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] seq_count,
    output logic             dc_vlc_run,
    output logic             dc_vlc_output_enable,
    output logic [CNT_W-1:0] dc_vlc_counter,
    output logic             ac_vlc_run,
    output logic             ac_vlc_output_enable,
    output logic             ac_vlc_output_flush,
    output logic [CNT_W-1:0] ac_vlc_counter
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DCT  = 3'd1,
        ST_DC   = 3'd2,
        ST_AC   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_dct_lat     = CNT_W'(DCT_LAT);
    localparam logic [CNT_W-1:0] c_dc_vlc_lat  = CNT_W'(DC_VLC_LAT);
    localparam logic [CNT_W-1:0] c_ac_coefs    = CNT_W'(COEFS - 1);
    localparam logic [CNT_W-1:0] c_dc_en_dly   = CNT_W'(DC_EN_DLY);
    localparam logic [CNT_W-1:0] c_ac_en_dly   = CNT_W'(AC_EN_DLY);
    localparam logic [CNT_W-1:0] c_dc_run_tail = CNT_W'(DC_RUN_TAIL);
    localparam logic [CNT_W-1:0] c_ac_run_tail = CNT_W'(AC_RUN_TAIL);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_n;

    state_t           w_nxt_state;
    logic [CNT_W-1:0] w_nxt_count;
    logic [CNT_W-1:0] w_nxt_n;
    logic             w_accept;
    logic             w_reject;
    logic [CNT_W-1:0] w_a;
    logic [CNT_W-1:0] w_b;
    logic [CNT_W-1:0] w_m;
    logic [CNT_W-1:0] w_end;
    logic             w_live;
    logic             w_dc_run;
    logic             w_dc_oe;
    logic             w_ac_run;
    logic             w_ac_oe;
    logic             w_ac_flush;

    // Only an idle sequencer with a non-empty slice accepts; anything else
    // that raises slice_start is reported and otherwise ignored.
    assign w_accept = slice_start && (r_state == ST_IDLE) && (block_num != '0);
    assign w_reject = slice_start && !w_accept;
    assign w_nxt_n  = w_accept ? CNT_W'(block_num) : r_n;

    // Window bases. N only changes on acceptance out of IDLE, so bases built
    // from the next-cycle N serve both the state transitions (which only use
    // them outside IDLE) and the registered output windows.
    assign w_a   = c_dct_lat + w_nxt_n;
    assign w_b   = w_a + c_dc_vlc_lat;
    assign w_m   = c_ac_coefs * w_nxt_n;
    assign w_end = w_b + w_m + c_ac_run_tail + c_one;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_count = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nxt_state = ST_DCT;
                end
            end
            ST_DCT: begin
                w_nxt_count = r_count + c_one;
                if (r_count == w_a - c_one) begin
                    w_nxt_state = ST_DC;
                end
            end
            ST_DC: begin
                w_nxt_count = r_count + c_one;
                if (r_count == w_b - c_one) begin
                    w_nxt_state = ST_AC;
                end
            end
            ST_AC: begin
                w_nxt_count = r_count + c_one;
                if (r_count == w_end - c_one) begin
                    w_nxt_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Output windows are evaluated on the count the next cycle will carry so
    // that the registered outputs line up with seq_count in the same cycle.
    assign w_live     = (w_nxt_state != ST_IDLE);
    assign w_dc_run   = w_live && (w_nxt_count >= w_a + c_one)
                               && (w_nxt_count <= w_a + w_nxt_n + c_dc_run_tail);
    assign w_dc_oe    = w_live && (w_nxt_count >= w_a + c_dc_en_dly)
                               && (w_nxt_count <  w_a + c_dc_en_dly + w_nxt_n);
    assign w_ac_run   = w_live && (w_nxt_count >= w_b + c_one)
                               && (w_nxt_count <= w_b + w_m + c_ac_run_tail);
    assign w_ac_oe    = w_live && (w_nxt_count >= w_b + c_ac_en_dly)
                               && (w_nxt_count <  w_b + c_ac_en_dly + w_m);
    assign w_ac_flush = w_live && (w_nxt_count == w_b + c_ac_en_dly + w_m);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state              <= ST_IDLE;
            r_count              <= '0;
            r_n                  <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            start_err            <= 1'b0;
            dc_vlc_run           <= 1'b0;
            dc_vlc_output_enable <= 1'b0;
            dc_vlc_counter       <= '0;
            ac_vlc_run           <= 1'b0;
            ac_vlc_output_enable <= 1'b0;
            ac_vlc_output_flush  <= 1'b0;
            ac_vlc_counter       <= '0;
        end else begin
            r_state              <= w_nxt_state;
            r_count              <= w_nxt_count;
            r_n                  <= w_nxt_n;
            busy                 <= (w_nxt_state == ST_DCT) || (w_nxt_state == ST_DC)
                                    || (w_nxt_state == ST_AC);
            done                 <= (w_nxt_state == ST_DONE);
            start_err            <= w_reject;
            dc_vlc_run           <= w_dc_run;
            dc_vlc_output_enable <= w_dc_oe;
            dc_vlc_counter       <= w_dc_run ? (w_nxt_count - (w_a + c_one)) : '0;
            ac_vlc_run           <= w_ac_run;
            ac_vlc_output_enable <= w_ac_oe;
            ac_vlc_output_flush  <= w_ac_flush;
            ac_vlc_counter       <= w_ac_run ? (w_nxt_count - (w_b + c_one)) : '0;
        end
    end

    assign state     = r_state;
    assign seq_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_slice_vlc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slice_vlc_sequencer
//  Purpose  : Self-checking bench for slice_vlc_sequencer. A slice-level model
//             (active flag, cycle index, block count) predicts every output
//             each cycle from the window formulas of the slice timeline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slice_vlc_sequencer;

    localparam int CNT_W       = 16;
    localparam int BN_W        = 8;
    localparam int COEFS       = 64;
    localparam int DCT_LAT     = 10;
    localparam int DC_VLC_LAT  = 44;
    localparam int DC_EN_DLY   = 7;
    localparam int AC_EN_DLY   = 6;
    localparam int DC_RUN_TAIL = 8;
    localparam int AC_RUN_TAIL = 8;
    localparam int VW          = 3 + 3 + CNT_W + 2 + CNT_W + 3 + CNT_W;

    logic             clock       = 1'b0;
    logic             reset_n     = 1'b0;
    logic             slice_start = 1'b0;
    logic [BN_W-1:0]  block_num   = '0;
    logic             busy, done, start_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] seq_count, dc_vlc_counter, ac_vlc_counter;
    logic             dc_vlc_run, dc_vlc_output_enable;
    logic             ac_vlc_run, ac_vlc_output_enable, ac_vlc_output_flush;

    slice_vlc_sequencer #(
        .CNT_W(CNT_W), .BN_W(BN_W), .COEFS(COEFS), .DCT_LAT(DCT_LAT),
        .DC_VLC_LAT(DC_VLC_LAT), .DC_EN_DLY(DC_EN_DLY), .AC_EN_DLY(AC_EN_DLY),
        .DC_RUN_TAIL(DC_RUN_TAIL), .AC_RUN_TAIL(AC_RUN_TAIL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .slice_start(slice_start),
        .block_num(block_num), .busy(busy), .done(done), .start_err(start_err),
        .state(state), .seq_count(seq_count), .dc_vlc_run(dc_vlc_run),
        .dc_vlc_output_enable(dc_vlc_output_enable), .dc_vlc_counter(dc_vlc_counter),
        .ac_vlc_run(ac_vlc_run), .ac_vlc_output_enable(ac_vlc_output_enable),
        .ac_vlc_output_flush(ac_vlc_output_flush), .ac_vlc_counter(ac_vlc_counter)
    );

    always #5 clock = ~clock;

    wire [VW-1:0] dut_vec = {busy, done, start_err, state, seq_count,
                             dc_vlc_run, dc_vlc_output_enable, dc_vlc_counter,
                             ac_vlc_run, ac_vlc_output_enable, ac_vlc_output_flush,
                             ac_vlc_counter};

    int total = 0;
    int bad   = 0;

    // Slice-level model: m_active covers acceptance through the done cycle.
    bit m_active = 0;
    int m_c      = 0;
    int m_n      = 0;
    bit m_err    = 0;

    function automatic int slice_end(input int n);
        return DCT_LAT + n + DC_VLC_LAT + (COEFS - 1) * n + AC_RUN_TAIL + 1;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        int a, b, m, e;
        logic bz, dn, dr, doe, ar, aoe, fl;
        logic [2:0] st;
        logic [CNT_W-1:0] sc, dcc, acc;
        a = DCT_LAT + m_n;
        b = a + DC_VLC_LAT;
        m = (COEFS - 1) * m_n;
        e = slice_end(m_n);
        bz = 0; dn = 0; dr = 0; doe = 0; ar = 0; aoe = 0; fl = 0;
        st = 3'd0; sc = '0; dcc = '0; acc = '0;
        if (m_active) begin
            sc  = CNT_W'(m_c);
            st  = (m_c < a) ? 3'd1 : (m_c < b) ? 3'd2 : (m_c < e) ? 3'd3 : 3'd4;
            bz  = (st != 3'd4);
            dn  = (st == 3'd4);
            dr  = (m_c >= a + 1) && (m_c <= a + m_n + DC_RUN_TAIL);
            doe = (m_c >= a + DC_EN_DLY) && (m_c <= a + DC_EN_DLY + m_n - 1);
            ar  = (m_c >= b + 1) && (m_c <= b + m + AC_RUN_TAIL);
            aoe = (m_c >= b + AC_EN_DLY) && (m_c <= b + AC_EN_DLY + m - 1);
            fl  = (m_c == b + AC_EN_DLY + m);
            dcc = dr ? CNT_W'(m_c - (a + 1)) : '0;
            acc = ar ? CNT_W'(m_c - (b + 1)) : '0;
        end
        return {bz, dn, m_err, st, sc, dr, doe, dcc, ar, aoe, fl, acc};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, and
    // leave time at edge+1 for sampling.
    task automatic tick(input bit st, input int bn);
        bit acc;
        slice_start = st;
        block_num   = BN_W'(bn);
        @(posedge clock);
        acc   = st && !m_active && (bn != 0);
        m_err = st && !acc;
        if (m_active) begin
            if (m_c == slice_end(m_n)) begin
                m_active = 0;
                m_c      = 0;
            end else begin
                m_c++;
            end
        end else if (acc) begin
            m_active = 1;
            m_c      = 0;
            m_n      = bn;
        end
        #1;
        slice_start = 1'b0;
        block_num   = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (dut_vec !== '0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=0", dut_vec);
        end
        #2 reset_n = 1'b1;
        tick(0, 0);
        total++;
        if (dut_vec !== model_vec()) begin
            bad++;
            $display("FAIL reset_idle got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_single_n4();
        int dr_f = -1, dr_l = -1, doe_f = -1, doe_l = -1, ar_f = -1, ar_l = -1;
        int aoe_f = -1, aoe_l = -1, fl_n = 0, fl_c = -1, dn_c = -1;
        int dcc15 = -1, dcc26 = -1, acc59 = -1, acc318 = -1, outside_bad = 0;
        int guard = 0;
        tick(1, 4);
        while (m_active && guard < 1000) begin
            total++;
            if (dut_vec !== model_vec()) begin
                bad++;
                $display("FAIL n4_cycle c=%0d got=%h exp=%h", m_c, dut_vec, model_vec());
            end
            if (dc_vlc_run) begin if (dr_f < 0) dr_f = m_c; dr_l = m_c; end
            if (dc_vlc_output_enable) begin if (doe_f < 0) doe_f = m_c; doe_l = m_c; end
            if (ac_vlc_run) begin if (ar_f < 0) ar_f = m_c; ar_l = m_c; end
            if (ac_vlc_output_enable) begin if (aoe_f < 0) aoe_f = m_c; aoe_l = m_c; end
            if (ac_vlc_output_flush) begin fl_n++; fl_c = m_c; end
            if (done) dn_c = m_c;
            if (m_c == 15)  dcc15  = int'(dc_vlc_counter);
            if (m_c == 26)  dcc26  = int'(dc_vlc_counter);
            if (m_c == 59)  acc59  = int'(ac_vlc_counter);
            if (m_c == 318) acc318 = int'(ac_vlc_counter);
            if ((!dc_vlc_run && dc_vlc_counter != 0) || (!ac_vlc_run && ac_vlc_counter != 0))
                outside_bad++;
            tick(0, 0);
            guard++;
        end
        total++;
        if (guard >= 1000) begin bad++; $display("FAIL n4_timeout cycles=%0d limit=1000", guard); end
        total++;
        if (dr_f != 15 || dr_l != 26) begin
            bad++; $display("FAIL n4_dc_run got=%0d..%0d exp=15..26", dr_f, dr_l);
        end
        total++;
        if (doe_f != 21 || doe_l != 24) begin
            bad++; $display("FAIL n4_dc_oe got=%0d..%0d exp=21..24", doe_f, doe_l);
        end
        total++;
        if (ar_f != 59 || ar_l != 318) begin
            bad++; $display("FAIL n4_ac_run got=%0d..%0d exp=59..318", ar_f, ar_l);
        end
        total++;
        if (aoe_f != 64 || aoe_l != 315) begin
            bad++; $display("FAIL n4_ac_oe got=%0d..%0d exp=64..315", aoe_f, aoe_l);
        end
        total++;
        if (fl_n != 1 || fl_c != 316) begin
            bad++; $display("FAIL n4_flush got=%0d@%0d exp=1@316", fl_n, fl_c);
        end
        total++;
        if (dn_c != 319) begin bad++; $display("FAIL n4_done got=%0d exp=319", dn_c); end
        total++;
        if (dcc15 != 0 || dcc26 != 11) begin
            bad++; $display("FAIL n4_dc_counter got=%0d,%0d exp=0,11", dcc15, dcc26);
        end
        total++;
        if (acc59 != 0 || acc318 != 259) begin
            bad++; $display("FAIL n4_ac_counter got=%0d,%0d exp=0,259", acc59, acc318);
        end
        total++;
        if (outside_bad != 0) begin
            bad++; $display("FAIL n4_counter_outside got=%0d exp=0", outside_bad);
        end
        total++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL n4_back_idle state=%0d busy=%b exp=0,0", state, busy);
        end
    endtask

    task automatic test_single_n1();
        int doe_f = -1, doe_n = 0, aoe_f = -1, aoe_n = 0, fl_c = -1, dn_c = -1, guard = 0;
        tick(1, 1);
        while (m_active && guard < 1000) begin
            total++;
            if (dut_vec !== model_vec()) begin
                bad++;
                $display("FAIL n1_cycle c=%0d got=%h exp=%h", m_c, dut_vec, model_vec());
            end
            if (dc_vlc_output_enable) begin if (doe_f < 0) doe_f = m_c; doe_n++; end
            if (ac_vlc_output_enable) begin if (aoe_f < 0) aoe_f = m_c; aoe_n++; end
            if (ac_vlc_output_flush) fl_c = m_c;
            if (done) dn_c = m_c;
            tick(0, 0);
            guard++;
        end
        total++;
        if (doe_f != 18 || doe_n != 1) begin
            bad++; $display("FAIL n1_dc_oe got=%0dx%0d exp=18x1", doe_f, doe_n);
        end
        total++;
        if (aoe_f != 61 || aoe_n != 63) begin
            bad++; $display("FAIL n1_ac_oe got=%0dx%0d exp=61x63", aoe_f, aoe_n);
        end
        total++;
        if (fl_c != 124 || dn_c != 127) begin
            bad++; $display("FAIL n1_flush_done got=%0d,%0d exp=124,127", fl_c, dn_c);
        end
    endtask

    task automatic test_zero_blocks();
        tick(1, 0);
        total++;
        if (start_err !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_start err=%b busy=%b exp=1,0", start_err, busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL zero_quiet got=%h exp=%h", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard = 0, dn_c = -1;
        tick(1, 4);
        while (m_c < 100 && guard < 200) begin tick(0, 0); guard++; end
        tick(1, 9);
        total++;
        if (start_err !== 1'b1 || dut_vec !== model_vec()) begin
            bad++; $display("FAIL busy_reject err=%b got=%h exp=%h", start_err, dut_vec, model_vec());
        end
        while (!(m_active && m_c == slice_end(4)) && guard < 1000) begin
            tick(0, 0);
            guard++;
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL b2b_n4 c=%0d got=%h exp=%h", m_c, dut_vec, model_vec());
            end
        end
        total++;
        if (done !== 1'b1 || seq_count !== 16'd319) begin
            bad++; $display("FAIL b2b_n4_done done=%b c=%0d exp=1,319", done, seq_count);
        end
        tick(1, 9);
        total++;
        if (start_err !== 1'b1 || state !== 3'd0) begin
            bad++; $display("FAIL done_reject err=%b state=%0d exp=1,0", start_err, state);
        end
        tick(1, 9);
        total++;
        if (busy !== 1'b1 || seq_count !== 16'd0 || start_err !== 1'b0) begin
            bad++; $display("FAIL b2b_accept busy=%b c=%0d err=%b exp=1,0,0", busy, seq_count, start_err);
        end
        guard = 0;
        while (m_active && guard < 1000) begin
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL b2b_n9 c=%0d got=%h exp=%h", m_c, dut_vec, model_vec());
            end
            if (done) dn_c = m_c;
            tick(0, 0);
            guard++;
        end
        total++;
        if (dn_c != 639) begin bad++; $display("FAIL b2b_n9_done got=%0d exp=639", dn_c); end
    endtask

    task automatic test_reset_mid();
        int guard = 0, fl_n = 0, dr_f = -1, dr_l = -1;
        tick(1, 4);
        while (m_c < 70 && guard < 200) begin tick(0, 0); guard++; end
        #2 reset_n = 1'b0;
        #1;
        m_active = 0; m_c = 0; m_err = 0;
        total++;
        if (dut_vec !== '0) begin
            bad++; $display("FAIL reset_mid_async got=%h exp=0", dut_vec);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            if (ac_vlc_output_flush || done) fl_n++;
        end
        total++;
        if (fl_n != 0 || dut_vec !== '0) begin
            bad++; $display("FAIL reset_mid_hold flush_or_done=%0d got=%h exp=0", fl_n, dut_vec);
        end
        #2 reset_n = 1'b1;
        tick(1, 2);
        guard = 0;
        while (m_active && guard < 1000) begin
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL restart_n2 c=%0d got=%h exp=%h", m_c, dut_vec, model_vec());
            end
            if (dc_vlc_run) begin if (dr_f < 0) dr_f = m_c; dr_l = m_c; end
            tick(0, 0);
            guard++;
        end
        total++;
        if (dr_f != 13 || dr_l != 22) begin
            bad++; $display("FAIL restart_dc_run got=%0d..%0d exp=13..22", dr_f, dr_l);
        end
    endtask

    task automatic test_random();
        int cycles = 0;
        for (int s = 0; s < 6; s++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                tick(($urandom_range(0, 3) == 0), 0);
                total++;
                if (dut_vec !== model_vec()) begin
                    bad++; $display("FAIL rand_gap got=%h exp=%h", dut_vec, model_vec());
                end
            end
            tick(1, int'($urandom_range(0, 5)));
            cycles = 0;
            while (cycles < 1000) begin
                total++;
                if (dut_vec !== model_vec()) begin
                    bad++;
                    $display("FAIL rand_slice n=%0d c=%0d got=%h exp=%h", m_n, m_c, dut_vec, model_vec());
                end
                if (!m_active) break;
                tick(($urandom_range(0, 31) == 0), int'($urandom_range(0, 9)));
                cycles++;
            end
            total++;
            if (cycles >= 1000) begin bad++; $display("FAIL rand_timeout cycles=%0d limit=1000", cycles); end
        end
    endtask

    initial begin
        test_reset();
        test_single_n4();
        test_single_n1();
        test_zero_blocks();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
